c_elem_handshake_sync: RTL and testbench

- Clocked consumer stage directly downstream of the Muller C-element.
- Synchronises the asynchronous C-element output into the clock domain and closes a four-phase req/ack loop by driving the acknowledge back to the C-element inputs.
- Counts completed handshakes and flags a stalled loop.
- Results go out to the user IO / logic-analyser bank for observation.

---
 rtl/c_elem_handshake_sync_pkg.sv | 15 +
 rtl/sync_ff_chain.sv | 21 ++
 rtl/c_elem_handshake_sync.sv | 112 +++++++++++
 tb/tb_c_elem_handshake_sync.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/c_elem_handshake_sync_pkg.sv
// Shared types and widths for the clocked consumer stage behind the Muller C-element.
package c_elem_handshake_sync_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DELAY,
    S_ACK,
    S_REL,
    S_ERR
  } state_e;

  localparam int DLY_W = 4;   // holds ACK_DELAY-1 for ACK_DELAY up to 15
  localparam int TMR_W = 16;  // stall timer, TIMEOUT up to 65535

endpackage

// File: rtl/sync_ff_chain.sv
// Plain flop chain for bringing an asynchronous level into the clock domain.
module sync_ff_chain #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] ff;

  // NOTE: non-blocking shift so every flop takes its neighbour's pre-edge value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ff <= '0;
    else     ff <= {ff[DEPTH-2:0], d};
  end

  assign q = ff[DEPTH-1];

endmodule

// File: rtl/c_elem_handshake_sync.sv
// Closes the four-phase req/ack loop around a C-element, counts completed
// handshakes and flags a loop that stays stuck with ack high.
module c_elem_handshake_sync
  import c_elem_handshake_sync_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int ACK_DELAY   = 0,
  parameter int TIMEOUT     = 255,
  parameter int CNT_W       = 8
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             c_out_i,
  input  logic             enable_i,
  input  logic             clr_i,
  output logic             ack_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] count_o,
  output logic             timeout_o
);

  localparam logic [DLY_W-1:0] DLY_LOAD = DLY_W'((ACK_DELAY > 0) ? ACK_DELAY - 1 : 0);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  logic             req_s;
  state_e           state;
  logic [DLY_W-1:0] dly_cnt;
  logic [TMR_W-1:0] tmr_cnt;
  logic             stall_hit;

  sync_ff_chain #(.DEPTH(SYNC_STAGES)) u_sync (
    .clk (wb_clk_i),
    .rst (wb_rst_i),
    .d   (c_out_i),
    .q   (req_s)
  );

  assign stall_hit = (state == S_ACK) && req_s && (tmr_cnt == TMR_LAST);

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state     <= S_IDLE;
      ack_o     <= 1'b0;
      busy_o    <= 1'b0;
      count_o   <= '0;
      timeout_o <= 1'b0;
      dly_cnt   <= '0;
      tmr_cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_s && enable_i) begin
            busy_o <= 1'b1;
            if (ACK_DELAY > 0) begin
              state   <= S_DELAY;
              dly_cnt <= DLY_LOAD;
            end else begin
              state   <= S_ACK;
              ack_o   <= 1'b1;
              tmr_cnt <= '0;
            end
          end
        end
        // The C-element holds its output until acked, so req_s is not watched here.
        S_DELAY: begin
          if (dly_cnt == '0) begin
            state   <= S_ACK;
            ack_o   <= 1'b1;
            tmr_cnt <= '0;
          end else begin
            dly_cnt <= dly_cnt - 1'b1;
          end
        end
        S_ACK: begin
          if (!req_s) begin
            state <= S_REL;
            ack_o <= 1'b0;
          end else if (tmr_cnt == TMR_LAST) begin
            state <= S_ERR;
          end else begin
            tmr_cnt <= tmr_cnt + 1'b1;
          end
        end
        S_ERR: begin
          if (!req_s) begin
            state <= S_REL;
            ack_o <= 1'b0;
          end
        end
        S_REL: begin
          state  <= S_IDLE;
          busy_o <= 1'b0;
        end
        default: begin
          state  <= S_IDLE;
          ack_o  <= 1'b0;
          busy_o <= 1'b0;
        end
      endcase

      // Clear has priority over both the count increment and a fresh stall.
      if (clr_i) begin
        count_o   <= '0;
        timeout_o <= 1'b0;
      end else begin
        if (state == S_REL) count_o <= count_o + 1'b1;
        if (stall_hit)      timeout_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_c_elem_handshake_sync.sv
// Two instances (default and delayed/short-timeout/narrow-count) checked every
// cycle against a behavioural model, plus directed latency and corner scenarios.
module tb_c_elem_handshake_sync;

  localparam int SYNC = 2;
  localparam int AD0 = 0, TO0 = 255, CW0 = 8;
  localparam int AD1 = 4, TO1 = 10,  CW1 = 4;

  localparam int P_IDLE = 0, P_WAIT = 1, P_HOLD = 2, P_STUCK = 3, P_DONE = 4;
  localparam int SIG_ACK = 0, SIG_BUSY = 1, SIG_TOUT = 2;

  typedef struct packed {
    int       phase;
    int       wait_n;
    int       held;
    int       cnt;
    bit       tout;
    bit [3:0] hist;
  } mdl_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [1:0] c_out, en, clr;
  logic ack0, busy0, tout0, ack1, busy1, tout1;
  logic [CW0-1:0] count0;
  logic [CW1-1:0] count1;

  int   n_checks = 0;
  int   n_errors = 0;
  bit   chk_on   = 1'b0;
  mdl_t m [2];

  always #5 clk = ~clk;

  c_elem_handshake_sync #(.SYNC_STAGES(SYNC), .ACK_DELAY(AD0), .TIMEOUT(TO0), .CNT_W(CW0)) dut0 (
    .wb_clk_i(clk), .wb_rst_i(rst), .c_out_i(c_out[0]), .enable_i(en[0]), .clr_i(clr[0]),
    .ack_o(ack0), .busy_o(busy0), .count_o(count0), .timeout_o(tout0));

  c_elem_handshake_sync #(.SYNC_STAGES(SYNC), .ACK_DELAY(AD1), .TIMEOUT(TO1), .CNT_W(CW1)) dut1 (
    .wb_clk_i(clk), .wb_rst_i(rst), .c_out_i(c_out[1]), .enable_i(en[1]), .clr_i(clr[1]),
    .ack_o(ack1), .busy_o(busy1), .count_o(count1), .timeout_o(tout1));

  function automatic int cfg_ad(int k); return (k == 0) ? AD0 : AD1; endfunction
  function automatic int cfg_to(int k); return (k == 0) ? TO0 : TO1; endfunction
  function automatic int cfg_cw(int k); return (k == 0) ? CW0 : CW1; endfunction

  function automatic bit m_ack(mdl_t s);
    return (s.phase == P_HOLD) || (s.phase == P_STUCK);
  endfunction

  function automatic bit m_busy(mdl_t s);
    return s.phase != P_IDLE;
  endfunction

  // One clock edge of the handshake rules, given the inputs present at that edge.
  function automatic mdl_t step(mdl_t s, int k, bit c, bit e, bit cl);
    mdl_t n = s;
    bit   req = s.hist[SYNC-1];
    bit   done = 1'b0;
    bit   stall = 1'b0;
    n.hist = {s.hist[2:0], c};
    case (s.phase)
      P_IDLE:
        if (req && e) begin
          if (cfg_ad(k) > 0) begin n.phase = P_WAIT; n.wait_n = cfg_ad(k); end
          else begin n.phase = P_HOLD; n.held = 0; end
        end
      P_WAIT: begin
        n.wait_n = s.wait_n - 1;
        if (n.wait_n == 0) begin n.phase = P_HOLD; n.held = 0; end
      end
      P_HOLD:
        if (!req) n.phase = P_DONE;
        else begin
          n.held = s.held + 1;
          if (n.held == cfg_to(k)) begin n.phase = P_STUCK; stall = 1'b1; end
        end
      P_STUCK: if (!req) n.phase = P_DONE;
      default: begin n.phase = P_IDLE; done = 1'b1; end
    endcase
    if (cl) begin
      n.cnt = 0;
      n.tout = 1'b0;
    end else begin
      if (done)  n.cnt = (s.cnt + 1) % (1 << cfg_cw(k));
      if (stall) n.tout = 1'b1;
    end
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) m[k] <= '0;
    end else begin
      for (int k = 0; k < 2; k++) m[k] <= step(m[k], k, c_out[k], en[k], clr[k]);
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_dut(input int k, input logic a, input logic b, input int c, input logic t);
    check($sformatf("d%0d.ack", k),     int'(a), int'(m_ack(m[k])));
    check($sformatf("d%0d.busy", k),    int'(b), int'(m_busy(m[k])));
    check($sformatf("d%0d.count", k),   c,       m[k].cnt);
    check($sformatf("d%0d.timeout", k), int'(t), int'(m[k].tout));
  endtask

  always @(negedge clk) begin
    if (chk_on && !rst) begin
      check_dut(0, ack0, busy0, int'(count0), tout0);
      check_dut(1, ack1, busy1, int'(count1), tout1);
    end
  end

  function automatic int get_sig(int k, int sig);
    case (sig)
      SIG_ACK:  return (k == 0) ? int'(ack0)  : int'(ack1);
      SIG_BUSY: return (k == 0) ? int'(busy0) : int'(busy1);
      default:  return (k == 0) ? int'(tout0) : int'(tout1);
    endcase
  endfunction

  // Counts rising edges until the signal reaches val; -1 if the budget runs out.
  task automatic edges_until(input int k, input int sig, input int val, input int budget, output int n);
    n = -1;
    for (int e = 1; e <= budget; e++) begin
      @(posedge clk);
      #1;
      if (get_sig(k, sig) == val) begin
        n = e;
        break;
      end
    end
  endtask

  task automatic handshake(input int k);
    int n;
    @(negedge clk) c_out[k] = 1'b1;
    edges_until(k, SIG_ACK, 1, 30, n);
    check($sformatf("hs.ack.d%0d", k), n > 0 ? 1 : 0, 1);
    @(negedge clk) c_out[k] = 1'b0;
    edges_until(k, SIG_BUSY, 0, 30, n);
    check($sformatf("hs.idle.d%0d", k), n > 0 ? 1 : 0, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    int pct [2];
    c_out = '0;
    en    = 2'b11;
    clr   = '0;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_on = 1'b1;
    check("rst.ack0", int'(ack0), 0);
    check("rst.busy0", int'(busy0), 0);
    check("rst.count0", int'(count0), 0);
    check("rst.tout1", int'(tout1), 0);

    // Default latency: rise and fall each take three edges, count follows one edge later.
    repeat (4) @(negedge clk);
    c_out[0] = 1'b1;
    edges_until(0, SIG_ACK, 1, 10, n);
    check("lat.rise.d0", n, 3);
    @(negedge clk) c_out[0] = 1'b0;
    edges_until(0, SIG_ACK, 0, 10, n);
    check("lat.fall.d0", n, 3);
    @(posedge clk);
    #1;
    check("done.count0", int'(count0), 1);
    check("done.busy0", int'(busy0), 0);

    // ACK_DELAY=4 with a req glitch while the delay is running.
    @(negedge clk) c_out[1] = 1'b1;
    n = -1;
    for (int e = 1; e <= 20; e++) begin
      @(posedge clk);
      #1;
      if (ack1) begin
        n = e;
        break;
      end
      if (e == 3) c_out[1] = 1'b0;
      if (e == 4) c_out[1] = 1'b1;
    end
    check("lat.rise.d1", n, 7);

    // Stall with TIMEOUT=10, then release and clear.
    edges_until(1, SIG_TOUT, 1, 40, n);
    check("stall.edges.d1", n, 10);
    check("stall.ack.d1", int'(ack1), 1);
    @(negedge clk) c_out[1] = 1'b0;
    edges_until(1, SIG_BUSY, 0, 20, n);
    check("stall.release.d1", n, 4);
    check("stall.count.d1", int'(count1), 1);
    check("stall.sticky.d1", int'(tout1), 1);
    @(negedge clk) clr[1] = 1'b1;
    @(negedge clk) clr[1] = 1'b0;
    check("clr.tout.d1", int'(tout1), 0);
    check("clr.count.d1", int'(count1), 0);

    // 17 handshakes on the 4-bit counter wrap back to 1.
    for (int h = 0; h < 17; h++) handshake(1);
    check("wrap.count.d1", int'(count1), 1);

    // Enable low blocks the start; raising it acks on the very next edge.
    @(negedge clk);
    en[0] = 1'b0;
    c_out[0] = 1'b1;
    repeat (6) @(negedge clk);
    check("en.ack0", int'(ack0), 0);
    check("en.busy0", int'(busy0), 0);
    en[0] = 1'b1;
    @(posedge clk);
    #1;
    check("en.rise.ack0", int'(ack0), 1);
    @(negedge clk) c_out[0] = 1'b0;
    edges_until(0, SIG_BUSY, 0, 20, n);

    // Asynchronous reset between clock edges while ack is high.
    @(negedge clk) c_out[0] = 1'b1;
    edges_until(0, SIG_ACK, 1, 10, n);
    check("pre.rst.count0", int'(count0), 2);
    #3 rst = 1'b1;
    #1;
    check("arst.ack0", int'(ack0), 0);
    check("arst.busy0", int'(busy0), 0);
    check("arst.count0", int'(count0), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    edges_until(0, SIG_ACK, 1, 10, n);
    check("arst.restart.d0", n, 3);
    @(negedge clk) c_out[0] = 1'b0;
    edges_until(0, SIG_BUSY, 0, 20, n);

    // Randomised traffic: mostly protocol-following, with glitches, enable drops and clears.
    pct[0] = 50;
    pct[1] = 50;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (cyc % 200 == 0) pct[k] = int'($urandom_range(5, 80));
        if (int'($urandom_range(99)) < pct[k]) c_out[k] = ~m_ack(m[k]);
        if ($urandom_range(99) < 2) c_out[k] = ~c_out[k];
        en[k]  = ($urandom_range(99) < 90);
        clr[k] = ($urandom_range(99) < 2);
      end
    end
    @(negedge clk);
    en    = 2'b11;
    clr   = '0;
    c_out = '0;
    repeat (20) @(negedge clk);
    check("end.idle0", int'(busy0), 0);
    check("end.idle1", int'(busy1), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
